// File: rtl/screen_draw_sequencer.sv
// screen_draw_sequencer: clears and redraws a frame in two passes.
// The background source runs first, then the overlay source. Each source
// gets a settle window after its resetn is released before its stream is
// trusted. Pixels are registered once on their way to the VGA adapter.
// Optional build macro SEQ_OVL_SKIP_EN: overlay pixels whose colour equals
// OVL_KEY are passed through without a write enable (transparent overlay).
module screen_draw_sequencer #(
  parameter int         SETTLE  = 2,     // 1..8, ignored-stream cycles per source
  parameter logic [8:0] OVL_KEY = 9'h000 // transparent overlay colour
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] bg_x,
  input  logic [6:0] bg_y,
  input  logic [8:0] bg_colour,
  input  logic       bg_done,
  input  logic [7:0] ovl_x,
  input  logic [6:0] ovl_y,
  input  logic [8:0] ovl_colour,
  input  logic       ovl_done,
  output logic       bg_resetn,
  output logic       ovl_resetn,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [8:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE, BG_SETTLE, BG_DRAW, OVL_SETTLE, OVL_DRAW, FINISH
  } state_t;

  // Settle counter terminal value; SETTLE below 1 still spends one cycle.
  localparam int unsigned SL          = (SETTLE > 1) ? SETTLE - 1 : 0;
  localparam logic [2:0]  SETTLE_LAST = 3'(SL);

  state_t     state, state_nx;
  logic [2:0] settle_cnt, settle_cnt_nx;
  logic       ld_bg, ld_ovl;
  logic       ovl_keep;

`ifdef SEQ_OVL_SKIP_EN
  // Keyed overlay pixels update vga_* but never raise plot.
  assign ovl_keep = (ovl_colour != OVL_KEY);
`else
  // Every overlay pixel is written; the key is not consulted.
  assign ovl_keep = 1'b1;
  logic key_unused;
  assign key_unused = ^OVL_KEY;
`endif

  // State and settle counter; reset parks the block in IDLE immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      settle_cnt <= 3'd0;
    end else begin
      state      <= state_nx;
      settle_cnt <= settle_cnt_nx;
    end
  end

  // Next-state decode plus Moore outputs; source enables follow the state
  // directly so a source is stopped the cycle after it reports done.
  always_comb begin
    state_nx      = state;
    settle_cnt_nx = settle_cnt;
    bg_resetn     = 1'b0;
    ovl_resetn    = 1'b0;
    busy          = 1'b1;
    frame_done    = 1'b0;
    ld_bg         = 1'b0;
    ld_ovl        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = BG_SETTLE;
      end
      BG_SETTLE: begin
        bg_resetn = 1'b1;
        if (settle_cnt == SETTLE_LAST) begin
          settle_cnt_nx = 3'd0;
          state_nx      = BG_DRAW;
        end else begin
          settle_cnt_nx = settle_cnt + 3'd1;
        end
      end
      BG_DRAW: begin
        bg_resetn = 1'b1;
        ld_bg     = 1'b1;
        // The pixel presented alongside done is the final one and is kept.
        if (bg_done) state_nx = OVL_SETTLE;
      end
      OVL_SETTLE: begin
        ovl_resetn = 1'b1;
        if (settle_cnt == SETTLE_LAST) begin
          settle_cnt_nx = 3'd0;
          state_nx      = OVL_DRAW;
        end else begin
          settle_cnt_nx = settle_cnt + 3'd1;
        end
      end
      OVL_DRAW: begin
        ovl_resetn = 1'b1;
        ld_ovl     = 1'b1;
        if (ovl_done) state_nx = FINISH;
      end
      FINISH: begin
        frame_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pixel register: one cycle from source outputs to the VGA adapter, with
  // plot qualifying the same cycle. Outside DRAW states plot drops to 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 9'd0;
      plot       <= 1'b0;
    end else begin
      plot <= ld_bg | (ld_ovl & ovl_keep);
      if (ld_bg) begin
        vga_x      <= bg_x;
        vga_y      <= bg_y;
        vga_colour <= bg_colour;
      end else if (ld_ovl) begin
        vga_x      <= ovl_x;
        vga_y      <= ovl_y;
        vga_colour <= ovl_colour;
      end
    end
  end

endmodule

// File: tb/tb_screen_draw_sequencer.sv
// Bench for screen_draw_sequencer: models both pixel sources, queues every
// pixel that must reach the screen with the cycle it was presented, and
// checks each plot cycle against that queue plus directed expectations.
module tb_screen_draw_sequencer;
  localparam int         SETTLE  = 2;
  localparam logic [8:0] OVL_KEY = 9'h000;
`ifdef SEQ_OVL_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic       clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [7:0] bg_x = '0, ovl_x = '0, vga_x;
  logic [6:0] bg_y = '0, ovl_y = '0, vga_y;
  logic [8:0] bg_colour = '0, ovl_colour = '0, vga_colour;
  logic       bg_done = 1'b0, ovl_done = 1'b0;
  logic       bg_resetn, ovl_resetn, plot, busy, frame_done;

  always #5 clk = ~clk;

  screen_draw_sequencer #(.SETTLE(SETTLE), .OVL_KEY(OVL_KEY)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .bg_x(bg_x), .bg_y(bg_y), .bg_colour(bg_colour), .bg_done(bg_done),
    .ovl_x(ovl_x), .ovl_y(ovl_y), .ovl_colour(ovl_colour), .ovl_done(ovl_done),
    .bg_resetn(bg_resetn), .ovl_resetn(ovl_resetn),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] c;
    bit         ovl;
    int         cyc;
  } pix_t;

  pix_t q[$];
  int cyc = 0, checks = 0, errors = 0;
  int bg_plots = 0, ovl_plots = 0, fd_pulses = 0, first_plot_cyc = -1;
  logic [7:0] first_x;
  logic [6:0] first_y;
  logic [8:0] first_c;
  int nbg = 1, novl = 1, bg_age = 0, ovl_age = 0;
  bit done_hi = 1'b0, prev_fd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Background picture: pixel 0 is (39,39,1FF), then walks diagonally.
  function automatic pix_t bg_pix(int k);
    pix_t p;
    p.x = 8'(39 + k); p.y = 7'(39 + k); p.c = 9'(511 - k); p.ovl = 1'b0; p.cyc = 0;
    return p;
  endfunction

  // Overlay picture: pixels with k%5 in {3,4} carry colour 0.
  function automatic pix_t ovl_pix(int k);
    pix_t p;
    p.x = 8'(k * 3); p.y = 7'(k);
    p.c = ((k % 5) >= 3) ? 9'h000 : 9'(k + 1);
    p.ovl = 1'b1; p.cyc = 0;
    return p;
  endfunction

  function automatic bit visible(pix_t p);
    return !(p.ovl && SKIP && p.c == OVL_KEY);
  endfunction

  function automatic int ovl_visible_count(int n);
    int cnt = 0;
    for (int k = 0; k < n; k++) if (visible(ovl_pix(k))) cnt++;
    return cnt;
  endfunction

  // Source model: while its resetn is high a source emits junk for SETTLE
  // cycles, then its picture; pixels that must be drawn are queued.
  task automatic drive_sources();
    pix_t p;
    int   k;
    if (bg_resetn) begin
      if (bg_age < SETTLE) begin
        bg_x = 8'hFF; bg_y = 7'h7F; bg_colour = 9'h155; bg_done = done_hi;
      end else begin
        k = bg_age - SETTLE; p = bg_pix(k);
        bg_x = p.x; bg_y = p.y; bg_colour = p.c;
        bg_done = done_hi || (k >= nbg - 1);
        if (k < nbg) begin p.cyc = cyc; q.push_back(p); end
      end
      bg_age++;
    end else begin
      bg_age = 0; bg_x = 8'hFF; bg_y = 7'h7F; bg_colour = 9'h155; bg_done = done_hi;
    end
    if (ovl_resetn) begin
      if (ovl_age < SETTLE) begin
        ovl_x = 8'hFE; ovl_y = 7'h7E; ovl_colour = 9'h0AA; ovl_done = done_hi;
      end else begin
        k = ovl_age - SETTLE; p = ovl_pix(k);
        ovl_x = p.x; ovl_y = p.y; ovl_colour = p.c;
        ovl_done = done_hi || (k >= novl - 1);
        if (k < novl && visible(p)) begin p.cyc = cyc; q.push_back(p); end
      end
      ovl_age++;
    end else begin
      ovl_age = 0; ovl_x = 8'hFE; ovl_y = 7'h7E; ovl_colour = 9'h0AA; ovl_done = done_hi;
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    drive_sources();
  end

  // Per-cycle compare against the queued pixels and frame invariants.
  always @(negedge clk) begin : cmp
    pix_t e;
    if (resetn) begin
      checks++;
      if (bg_resetn && ovl_resetn) begin
        errors++; $display("FAIL resetn_overlap: both source enables high at cycle %0d", cyc);
      end
      if (plot) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL unexpected_plot: x=%0d y=%0d c=%h at cycle %0d, nothing expected", vga_x, vga_y, vga_colour, cyc);
        end else begin
          e = q.pop_front();
          if (vga_x !== e.x || vga_y !== e.y || vga_colour !== e.c || cyc != e.cyc + 1) begin
            errors++;
            $display("FAIL pixel: got x=%0d y=%0d c=%h cyc=%0d, expected x=%0d y=%0d c=%h cyc=%0d",
                     vga_x, vga_y, vga_colour, cyc, e.x, e.y, e.c, e.cyc + 1);
          end
          if (e.ovl) ovl_plots++; else bg_plots++;
          if (first_plot_cyc < 0) begin
            first_plot_cyc = cyc; first_x = vga_x; first_y = vga_y; first_c = vga_colour;
          end
        end
      end
      if (frame_done) begin
        checks++; fd_pulses++;
        if (prev_fd || q.size() != 0) begin
          errors++; $display("FAIL frame_done: prev=%0d pending_pixels=%0d, expected 0 and 0", prev_fd, q.size());
        end
      end
      prev_fd = frame_done;
    end else begin
      prev_fd = 1'b0;
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++; $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic new_run(int b, int o, bit dh);
    nbg = b; novl = o; done_hi = dh;
    bg_plots = 0; ovl_plots = 0; fd_pulses = 0; first_plot_cyc = -1;
  endtask

  task automatic pulse_start(output int sc);
    @(posedge clk); #1 start = 1'b1; sc = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); #1; n++; end
    chk("busy_after_run", int'(busy), 0);
  endtask

  initial begin : main
    int sc, n;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bg_resetn", int'(bg_resetn), 0);
    chk("rst_ovl_resetn", int'(ovl_resetn), 0);
    chk("rst_vga_x", int'(vga_x), 0);
    chk("rst_vga_y", int'(vga_y), 0);
    chk("rst_vga_colour", int'(vga_colour), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    @(negedge clk) resetn = 1'b1;
    repeat (2) @(posedge clk);

    // Short frame: first-pixel value/latency, overlay key handling
    new_run(5, 10, 1'b0);
    pulse_start(sc);
    wait_idle(200);
    chk("first_plot_latency", first_plot_cyc - sc, SETTLE + 2);
    chk("first_x", int'(first_x), 39);
    chk("first_y", int'(first_y), 39);
    chk("first_colour", int'(first_c), 'h1FF);
    chk("short_bg_plots", bg_plots, 5);
    chk("short_ovl_plots", ovl_plots, SKIP ? 6 : 10);
    chk("short_frame_done", fd_pulses, 1);

    // Full-size frame: 3200 + 3200 pixels
    new_run(3200, 3200, 1'b0);
    pulse_start(sc);
    wait_idle(7000);
    chk("full_plots", bg_plots + ovl_plots, SKIP ? 3200 + ovl_visible_count(3200) : 6400);
    chk("full_frame_done", fd_pulses, 1);

    // start during BG_DRAW and during FINISH is ignored
    new_run(20, 6, 1'b0);
    pulse_start(sc);
    n = 0;
    while (bg_plots < 3 && n < 100) begin @(negedge clk); #1; n++; end
    chk("bgdraw_reached", int'(bg_plots >= 3), 1);
    pulse_start(sc);
    n = 0;
    while (!frame_done && n < 200) begin @(negedge clk); n++; end
    chk("finish_reached", int'(frame_done), 1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("no_restart_busy", int'(busy), 0);
    chk("no_restart_bg", bg_plots, 20);
    chk("no_restart_ovl", ovl_plots, SKIP ? 4 : 6);
    chk("no_restart_fd", fd_pulses, 1);

    // done flags held high everywhere: one pixel per source
    new_run(1, 1, 1'b1);
    repeat (3) @(posedge clk);
    chk("done_hi_idle", int'(busy), 0);
    pulse_start(sc);
    wait_idle(50);
    done_hi = 1'b0;
    chk("done_hi_bg", bg_plots, 1);
    chk("done_hi_ovl", ovl_plots, 1);
    chk("done_hi_fd", fd_pulses, 1);

    // Reset in the middle of OVL_DRAW
    new_run(4, 50, 1'b0);
    pulse_start(sc);
    n = 0;
    while (ovl_plots < 5 && n < 100) begin @(negedge clk); #1; n++; end
    chk("ovl_draw_reached", int'(ovl_plots >= 5), 1);
    @(posedge clk); #3 resetn = 1'b0;
    #1;
    chk("abort_plot", int'(plot), 0);
    chk("abort_bg_resetn", int'(bg_resetn), 0);
    chk("abort_ovl_resetn", int'(ovl_resetn), 0);
    chk("abort_frame_done", int'(frame_done), 0);
    chk("abort_busy", int'(busy), 0);
    q.delete();
    @(negedge clk) resetn = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("abort_stays_idle", int'(busy), 0);
    chk("abort_no_fd", fd_pulses, 0);

    // Normal frame after the abort
    new_run(3, 2, 1'b0);
    pulse_start(sc);
    wait_idle(100);
    chk("after_abort_bg", bg_plots, 3);
    chk("after_abort_ovl", ovl_plots, 2);
    chk("after_abort_fd", fd_pulses, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
